// File: rtl/apollo_chip_pkg.sv
// Shared types and default widths for the apollo chip command sequencer.
// Latency: n/a (types only). Backpressure: n/a.
// Optional feature macro used by the top: APOLLO_CHIP_DATA_SYNC_EN.
package apollo_chip_pkg;

    localparam int N_ARRAY_DEF    = 2;
    localparam int ADDR_COL_W_DEF = 5;
    localparam int ADDR_ROW_W_DEF = 5;
    localparam int CNT_W_DEF      = 8;

    typedef enum logic [1:0] {
        OP_INFER  = 2'b00,
        OP_RD_REG = 2'b01,
        OP_RD_MEM = 2'b10,
        OP_PROG   = 2'b11
    } chip_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_RESP
    } ctrl_state_e;

    typedef struct packed {
        logic cbl;
        logic cblen;
        logic csl;
        logic cwl;
    } strobe_t;

    // Only a prog operation drives the bit line; every op fires the select/word lines.
    function automatic strobe_t pulse_strobes(chip_op_e op, logic wdata);
        strobe_t s;
        s.csl   = 1'b1;
        s.cwl   = 1'b1;
        s.cblen = (op == OP_PROG);
        s.cbl   = (op == OP_PROG) && wdata;
        return s;
    endfunction

endpackage

// File: rtl/apollo_phase_timer.sv
// Loadable phase down-counter; a load value of 0 counts as 1, done marks the last cycle.
// Latency: done asserts in the Nth cycle after a load of N. Backpressure: none.
// Counter width configurable via CntW.
module apollo_phase_timer #(
    parameter int CntW = 8
) (
    input  logic            clk_sys_in,
    input  logic            rst_sys_in,
    input  logic            load,
    input  logic [CntW-1:0] load_val,
    output logic            done
);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
        if (rst_sys_in) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val == '0) ? CntW'(1) : load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CntW'(1);
        end
    end

    assign done = (cnt == CntW'(1));

endmodule

// File: rtl/apollo_chip_ctrl.sv
// Command sequencer driving chip pins through setup/pulse/hold and returning lane data on reads.
// Latency: response strobe S+P+H+1 cycles after accept; ready only in IDLE, no response backpressure.
// APOLLO_CHIP_DATA_SYNC_EN adds a two-flop synchroniser on data_i (default: single register stage).
module apollo_chip_ctrl
    import apollo_chip_pkg::*;
#(
    parameter int NArray   = N_ARRAY_DEF,
    parameter int AddrColW = ADDR_COL_W_DEF,
    parameter int AddrRowW = ADDR_ROW_W_DEF,
    parameter int CntW     = CNT_W_DEF
) (
    input  logic                   clk_sys_in,
    input  logic                   rst_sys_in,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [AddrColW-1:0]    cmd_col_i,
    input  logic [AddrRowW-1:0]    cmd_row_i,
    input  logic                   cmd_wdata_i,
    input  logic [CntW-1:0]        cfg_setup_i,
    input  logic [CntW-1:0]        cfg_pulse_i,
    input  logic [CntW-1:0]        cfg_hold_i,
    output logic                   rsp_valid_o,
    output logic [(2**NArray)-1:0] rsp_data_o,
    output logic                   busy_o,
    output logic                   chip_clk_o,
    output logic                   cbl_o,
    output logic                   cblen_o,
    output logic                   csl_o,
    output logic                   cwl_o,
    output logic [1:0]             instr_o,
    output logic [AddrColW-1:0]    adr_col_o,
    output logic [AddrRowW-1:0]    adr_row_o,
    input  logic [(2**NArray)-1:0] data_i
);

    localparam int NLanes = 2**NArray;

    ctrl_state_e       state;
    chip_op_e          op_q;
    logic              wdata_q;
    logic [CntW-1:0]   pulse_len_q;
    logic [CntW-1:0]   hold_len_q;
    strobe_t           strb_q;
    logic [NLanes-1:0] lane_q;
    logic              accept;
    logic              tmr_load;
    logic [CntW-1:0]   tmr_val;
    logic              tmr_done;

    assign accept     = cmd_valid_i && cmd_ready_o;
    assign chip_clk_o = clk_sys_in;
    assign cbl_o      = strb_q.cbl;
    assign cblen_o    = strb_q.cblen;
    assign csl_o      = strb_q.csl;
    assign cwl_o      = strb_q.cwl;

    // One timer serves all phases: reload with the next phase length as each one ends.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = cfg_setup_i;
        case (state)
            ST_IDLE: begin
                tmr_load = accept;
                tmr_val  = cfg_setup_i;
            end
            ST_SETUP: begin
                tmr_load = tmr_done;
                tmr_val  = pulse_len_q;
            end
            ST_PULSE: begin
                tmr_load = tmr_done;
                tmr_val  = hold_len_q;
            end
            default: ;
        endcase
    end

    apollo_phase_timer #(.CntW(CntW)) u_timer (
        .clk_sys_in (clk_sys_in),
        .rst_sys_in (rst_sys_in),
        .load       (tmr_load),
        .load_val   (tmr_val),
        .done       (tmr_done)
    );

`ifdef APOLLO_CHIP_DATA_SYNC_EN
    logic [NLanes-1:0] lane_meta;

    always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
        if (rst_sys_in) begin
            lane_meta <= '0;
            lane_q    <= '0;
        end else begin
            lane_meta <= data_i;
            lane_q    <= lane_meta;
        end
    end
`else
    always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
        if (rst_sys_in) begin
            lane_q <= '0;
        end else begin
            lane_q <= data_i;
        end
    end
`endif

    always_ff @(posedge clk_sys_in or posedge rst_sys_in) begin
        if (rst_sys_in) begin
            state       <= ST_IDLE;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            strb_q      <= '0;
            instr_o     <= 2'b00;
            adr_col_o   <= '0;
            adr_row_o   <= '0;
            op_q        <= OP_INFER;
            wdata_q     <= 1'b0;
            pulse_len_q <= '0;
            hold_len_q  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (accept) begin
                        state       <= ST_SETUP;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        op_q        <= chip_op_e'(cmd_op_i);
                        wdata_q     <= cmd_wdata_i;
                        pulse_len_q <= cfg_pulse_i;
                        hold_len_q  <= cfg_hold_i;
                        instr_o     <= cmd_op_i;
                        adr_col_o   <= cmd_col_i;
                        adr_row_o   <= cmd_row_i;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        state  <= ST_PULSE;
                        strb_q <= pulse_strobes(op_q, wdata_q);
                    end
                end
                ST_PULSE: begin
                    if (tmr_done) begin
                        state  <= ST_HOLD;
                        strb_q <= '0;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        if (op_q == OP_PROG) begin
                            state       <= ST_IDLE;
                            busy_o      <= 1'b0;
                            cmd_ready_o <= 1'b1;
                        end else begin
                            state       <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= lane_q;
                        end
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    busy_o      <= 1'b0;
                    cmd_ready_o <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
